// File: rtl/icache_direct_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_direct_pkg;

    localparam int ICACHE_WORD_W = 32;
    localparam int ICACHE_SETS   = 16;
    localparam int ICACHE_IDX_W  = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W  = ICACHE_WORD_W - ICACHE_IDX_W - 2;

    // Fields of one cache frame at the default geometry.
    typedef struct packed {
        logic                     valid;
        logic [ICACHE_TAG_W-1:0]  tag;
        logic [ICACHE_WORD_W-1:0] data;
    } icache_frame_t;

    // Byte address split into tag, frame index and byte offset.
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits are served combinationally
// from the frame array; a miss latches the word address and performs one
// single-word refill through the memory controller handshake.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int SETS   = ICACHE_SETS,
    parameter int WORD_W = ICACHE_WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              flush,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    icache_state_t state_reg, state_next;
    logic [WORD_W-1:0] missaddr_reg, missaddr_next;

    logic [SETS-1:0]   valid_reg;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [WORD_W-1:0] data_mem [SETS];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             hit;
    logic             fill;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[WORD_W-1:IDX_W+2];
    assign miss_idx = missaddr_reg[IDX_W+1:2];
    assign miss_tag = missaddr_reg[WORD_W-1:IDX_W+2];

    assign hit  = imemREN & valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);
    // A refill lands only when data is returned and no flush discards it.
    assign fill = nRST & ~flush & (state_reg == FETCH) & ~iwait;

    // State register and latched miss address; flush forces IDLE.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg    <= IDLE;
            missaddr_reg <= '0;
        end else if (flush) begin
            state_reg    <= IDLE;
            missaddr_reg <= missaddr_reg;
        end else begin
            state_reg    <= state_next;
            missaddr_reg <= missaddr_next;
        end
    end

    // Per-frame valid bits, cleared together by reset or flush.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge CLK) begin
                if (!nRST || flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill && (miss_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data storage; contents are qualified by the valid bits.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= iload;
        end
    end

    // Next-state and output decode; reset and flush gate the outputs last.
    always_comb begin
        state_next    = state_reg;
        missaddr_next = missaddr_reg;
        ihit          = 1'b0;
        imemload      = '0;
        iREN          = 1'b0;
        iaddr         = '0;

        case (state_reg)
            IDLE: begin
                if (hit) begin
                    ihit     = 1'b1;
                    imemload = data_mem[req_idx];
                end else if (imemREN) begin
                    missaddr_next = {imemaddr[WORD_W-1:2], 2'b00};
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = missaddr_reg;
                if (!iwait) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (flush) begin
            ihit = 1'b0;
        end

        if (!nRST) begin
            ihit     = 1'b0;
            imemload = '0;
            iREN     = 1'b0;
            iaddr    = '0;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for the direct-mapped instruction cache.
module tb_icache_direct;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks;
    int failures;

    icache_direct #(.SETS(16), .WORD_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .flush    (flush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; flush = 1'b0;
        iwait = 1'b1; iload = 32'h0;
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if (ihit !== 1'b0) begin failures++; $display("FAIL reset_ihit: got %b expected 0", ihit); end
            checks++;
            if (iREN !== 1'b0) begin failures++; $display("FAIL reset_iREN: got %b expected 0", iREN); end
            checks++;
            if (iaddr !== 32'h0 || imemload !== 32'h0) begin
                failures++; $display("FAIL reset_buses: iaddr=%h imemload=%h expected 0/0", iaddr, imemload);
            end
            tick();
        end
        nRST = 1'b1;
        sample();
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle: ihit=%b iREN=%b expected 0/0", ihit, iREN);
        end
        tick();
        iwait = 1'b0; iload = 32'hDEAD0000;
        sample();
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h0) begin
            failures++; $display("FAIL post_reset_fetch: iREN=%b iaddr=%h expected 1/00000000", iREN, iaddr);
        end
        tick();
        sample();
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'hDEAD0000) begin
            failures++; $display("FAIL post_reset_hit: ihit=%b data=%h expected 1/dead0000", ihit, imemload);
        end
        tick();
        imemREN = 1'b0;
        $display("txn reset: done checks=%0d", checks);
    endtask

    task automatic test_cold_miss();
        imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b1; iload = 32'h0;
        sample();
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            failures++; $display("FAIL cold_idle: ihit=%b iREN=%b expected 0/0", ihit, iREN);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            iwait = (i == 3) ? 1'b0 : 1'b1;
            iload = (i == 3) ? 32'h2108000A : 32'h0;
            sample();
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h44 || ihit !== 1'b0) begin
                failures++; $display("FAIL cold_fetch%0d: iREN=%b iaddr=%h ihit=%b expected 1/00000044/0", i, iREN, iaddr, ihit);
            end
            tick();
        end
        iwait = 1'b1; iload = 32'h0;
        sample();
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h2108000A) begin
            failures++; $display("FAIL cold_hit: ihit=%b data=%h expected 1/2108000a", ihit, imemload);
        end
        tick();
        $display("txn cold_miss: addr=00000044 done");
    endtask

    task automatic test_repeat_hit();
        imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            checks++;
            if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== 32'h2108000A) begin
                failures++; $display("FAIL repeat_hit%0d: ihit=%b iREN=%b data=%h expected 1/0/2108000a", i, ihit, iREN, imemload);
            end
            tick();
        end
        $display("txn repeat_hit: 10 cycles done");
    endtask

    // Miss on addr, then return data immediately (one FETCH cycle).
    task automatic test_conflict();
        // 0x04 shares index 1 with 0x44 and evicts it
        imemREN = 1'b1; imemaddr = 32'h04; iwait = 1'b0; iload = 32'h11110004;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL conflict_miss04: got ihit=%b expected 0", ihit); end
        tick();
        sample();
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h04) begin
            failures++; $display("FAIL conflict_fetch04: iREN=%b iaddr=%h expected 1/00000004", iREN, iaddr);
        end
        tick();
        sample();
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h11110004) begin
            failures++; $display("FAIL conflict_hit04: ihit=%b data=%h expected 1/11110004", ihit, imemload);
        end
        tick();
        imemaddr = 32'h44; iload = 32'h2108000A;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL conflict_miss44: got ihit=%b expected 0", ihit); end
        tick();
        sample();
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h44) begin
            failures++; $display("FAIL conflict_fetch44: iREN=%b iaddr=%h expected 1/00000044", iREN, iaddr);
        end
        tick();
        imemaddr = 32'h04; iload = 32'h11110004;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL conflict_remiss04: got ihit=%b expected 0", ihit); end
        tick();
        sample();
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h04) begin
            failures++; $display("FAIL conflict_refetch04: iREN=%b iaddr=%h expected 1/00000004", iREN, iaddr);
        end
        tick();
        imemREN = 1'b0; iwait = 1'b1;
        $display("txn conflict: 04/44/04 done");
    endtask

    task automatic test_addr_change();
        imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1; iload = 32'h0;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL chg_miss80: got ihit=%b expected 0", ihit); end
        tick();
        imemaddr = 32'h100;
        sample();
        checks++;
        if (iaddr !== 32'h80 || iREN !== 1'b1) begin
            failures++; $display("FAIL chg_hold80: iaddr=%h iREN=%b expected 00000080/1", iaddr, iREN);
        end
        tick();
        iwait = 1'b0; iload = 32'h80808080;
        sample();
        checks++;
        if (iaddr !== 32'h80 || iREN !== 1'b1) begin
            failures++; $display("FAIL chg_fill80: iaddr=%h iREN=%b expected 00000080/1", iaddr, iREN);
        end
        tick();
        imemaddr = 32'h80; iwait = 1'b1;
        sample();
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h80808080) begin
            failures++; $display("FAIL chg_hit80: ihit=%b data=%h expected 1/80808080", ihit, imemload);
        end
        tick();
        imemaddr = 32'h100;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL chg_miss100: got ihit=%b expected 0", ihit); end
        tick();
        iwait = 1'b0; iload = 32'h01000100;
        sample();
        checks++;
        if (iaddr !== 32'h100 || iREN !== 1'b1) begin
            failures++; $display("FAIL chg_fetch100: iaddr=%h iREN=%b expected 00000100/1", iaddr, iREN);
        end
        tick();
        imemREN = 1'b0; iwait = 1'b1;
        $display("txn addr_change: 80 held, 100 missed");
    endtask

    task automatic test_flush();
        imemREN = 1'b1; imemaddr = 32'h08; iwait = 1'b1; iload = 32'h0;
        tick();
        tick();
        // refill data arrives in the same cycle as flush and must be dropped
        flush = 1'b1; iwait = 1'b0; iload = 32'h0BAD0BAD;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL flush_fetch_ihit: got %b expected 0", ihit); end
        tick();
        flush = 1'b0; iwait = 1'b1;
        sample();
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            failures++; $display("FAIL flush_idle08: ihit=%b iREN=%b expected 0/0", ihit, iREN);
        end
        tick();
        iwait = 1'b0; iload = 32'h08080808;
        sample();
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h08) begin
            failures++; $display("FAIL flush_refetch08: iREN=%b iaddr=%h expected 1/00000008", iREN, iaddr);
        end
        tick();
        iwait = 1'b1;
        sample();
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h08080808) begin
            failures++; $display("FAIL flush_hit08: ihit=%b data=%h expected 1/08080808", ihit, imemload);
        end
        // flush on a would-be hit masks ihit in that cycle
        flush = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL flush_mask_hit: got ihit=%b expected 0", ihit); end
        tick();
        flush = 1'b0;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL flush_cleared08: got ihit=%b expected 0", ihit); end
        tick();
        iwait = 1'b0; iload = 32'h08080808;
        tick();
        imemaddr = 32'h44; iwait = 1'b1;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL flush_miss44: got ihit=%b expected 0", ihit); end
        tick();
        iwait = 1'b0; iload = 32'h2108000A;
        sample();
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h44) begin
            failures++; $display("FAIL flush_fetch44: iREN=%b iaddr=%h expected 1/00000044", iREN, iaddr);
        end
        tick();
        imemREN = 1'b0; iwait = 1'b1;
        $display("txn flush: 08 dropped, 44 invalidated");
    endtask

    task automatic test_wrap();
        imemREN = 1'b1; imemaddr = 32'hFFFFFFFF; iwait = 1'b0; iload = 32'hCAFEF00D;
        sample();
        checks++;
        if (ihit !== 1'b0) begin failures++; $display("FAIL wrap_miss: got ihit=%b expected 0", ihit); end
        tick();
        sample();
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'hFFFFFFFC) begin
            failures++; $display("FAIL wrap_fetch: iREN=%b iaddr=%h expected 1/fffffffc", iREN, iaddr);
        end
        tick();
        imemaddr = 32'hFFFFFFFC; iwait = 1'b1;
        sample();
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'hCAFEF00D) begin
            failures++; $display("FAIL wrap_hit: ihit=%b data=%h expected 1/cafef00d", ihit, imemload);
        end
        tick();
        imemREN = 1'b0;
        $display("txn wrap: addr=fffffffc done");
    endtask

    initial begin
        checks = 0; failures = 0;
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0;
        iwait = 1'b1; iload = 32'h0;
        tick();
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_conflict();
        test_addr_change();
        test_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
